posit_round_arbiter: RTL and testbench
======================================

Name: posit_round_arbiter

Overview:
- Shares one registered posit rounding unit among NUM_REQ requesters.
- Each requester presents an unpacked posit, its trailing bits, a sticky bit and a rounding-mode select.
- Each cycle the block picks at most one requester round-robin, drives the shared round unit, and collects the result one cycle later.
- Results go into a small result FIFO and leave on a single valid/ready stream tagged with the requester ID.
- Sits between the accumulator/normalisation stages and posit packing.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- UNPACKED_BITS, 16, flat width of one unpacked posit word as carried by the round unit.
- TRAILING_BITS, 8, trailing-bit width per request (>=2).
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
- ID_BITS, $clog2(NUM_REQ), requester tag width.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when valid&ready.
- req_data  in  NUM_REQ*UNPACKED_BITS  unpacked posit; requester i at slice i.
- req_trailing  in  NUM_REQ*TRAILING_BITS  trailing bits per requester.
- req_sticky  in  NUM_REQ  sticky bit per requester.
- req_stochastic  in  NUM_REQ  1 = stochastic rounding, 0 = round-to-nearest-even.
- rnd_data  out  UNPACKED_BITS  to round unit input.
- rnd_trailing  out  TRAILING_BITS  to round unit.
- rnd_sticky  out  1  to round unit.
- rnd_stochastic  out  1  to round unit.
- rnd_result  in  UNPACKED_BITS  round unit registered output.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  UNPACKED_BITS  rounded result.
- out_id  out  ID_BITS  requester that issued the result.
- busy  out  1  in-flight or FIFO non-empty.

Behaviour:
- Reset (async assert, released synchronously to clock): rr_ptr=0, inflight=0, FIFO empty. Outputs: out_valid=0, req_ready=0, busy=0, out_id=0, out_data=0.
- Credit rule: may grant only when fifo_count + inflight < FIFO_DEPTH. If a pop occurs in the same cycle, the credit check uses the pre-pop count; conservative, no bypass.
- Arbitration:
  - Combinational over req_valid.
  - Search starts at rr_ptr, wraps modulo NUM_REQ; the first valid index wins.
  - req_ready is one-hot at the winner only when credit is available, else all zero.
  - req_ready never depends on anything but req_valid, rr_ptr and registered state.
- On grant of index g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - inflight <= 1.
  - inflight_id <= g.
  - rnd_* driven from slice g in the same cycle. When nothing is granted, rnd_* carry slice rr_ptr (don't-care for the datapath).
- With no grant, inflight <= 0 and rr_ptr holds.
- Latency:
  - Accept at cycle t.
  - rnd_result is valid in t+1 and is pushed into the FIFO with inflight_id at the end of t+1.
  - out_valid=1 from t+2.
  - Minimum accept-to-out latency is 2 cycles.
  - Throughput is 1/cycle sustained when out_ready=1.
- FIFO: registered head; out_data/out_id come from the head entry; pop on out_valid&out_ready; simultaneous push and pop allowed.
- Overflow: cannot occur by the credit rule. The bench asserts push while full never happens.
- Backpressure: with out_ready=0, grants continue until fifo_count+inflight == FIFO_DEPTH, then req_ready=0 until a pop.
- Ordering: results leave in grant order. out_id lets requesters demultiplex.
- Fairness: any continuously asserted req_valid is granted within NUM_REQ grants.
- Reset mid-operation: in-flight result and FIFO contents are discarded; no output after reset deassert until a new grant.
- busy = inflight | (fifo_count != 0).

Decomposition:
- Shared package posit_round_arb_pkg holds:
  - the result entry typedef {data[UNPACKED_BITS], id[ID_BITS]};
  - a helper function for the round-robin rotate/priority search.
- One natural sub-module: round_result_fifo, a parameterised sync FIFO with count output and async active-high reset, instantiated once.

Test Plan (NUM_REQ=4, FIFO_DEPTH=4, stub round unit = 1-cycle register of rnd_data XOR 16'h00FF):
- Single request: req_valid=4'b0100, data 16'h1234, out_ready=1 -> req_ready=4'b0100 at t; out_valid at t+2 with data 16'h12CB, id 2; busy low at t+3.
- All four requesters hold valid continuously from reset -> grants in order 0,1,2,3,0,…; out_id sequence 0,1,2,3, one per cycle after the 2-cycle fill.
- out_ready=0, requester 1 always valid -> exactly 4 grants, then req_ready=0. Raising out_ready for one cycle -> exactly one more grant the following cycle.
- Mode steering: requester 3 stochastic=1, trailing 8'hA5, sticky=1 -> rnd_stochastic=1, rnd_trailing=8'hA5, rnd_sticky=1 in the grant cycle.
- Reset asserted asynchronously mid-cycle with 3 FIFO entries and 1 in flight -> out_valid, req_ready and busy drop immediately. After release, no output until a new request; the first grant goes to requester 0.
- Simultaneous push and pop with FIFO full-minus-one -> count stays constant; no grant issued while count+inflight==4.

Source files
------------

// File: rtl/posit_round_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | posit_round_arb_pkg: shared types and round-robin search helper       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package posit_round_arb_pkg;

  localparam int unsigned RR_MAX_REQ        = 16;
  localparam int unsigned RR_IDX_W          = 4;
  localparam int unsigned DEF_UNPACKED_BITS = 16;
  localparam int unsigned DEF_ID_BITS       = 2;

  // Result entry for the default configuration (16-bit posit, 4 requesters)
  typedef struct packed {
    logic [DEF_UNPACKED_BITS-1:0] data;
    logic [DEF_ID_BITS-1:0]       id;
  } res_entry_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid index at or after ptr, wrapping modulo num (ptr < num)
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int unsigned           num);
    rr_pick_t    r;
    int unsigned s;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      s = 32'(ptr) + k;
      if (s >= num) s = s - num;
      if ((k < num) && !r.found && valid[s[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = s[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_result_fifo: sync FIFO with occupancy count, zeroed empty head  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module round_result_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/posit_round_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | posit_round_arbiter: round-robin sharing of one registered posit     |
// | rounding unit, results returned in grant order with requester tags   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module posit_round_arbiter
  import posit_round_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int UNPACKED_BITS = 16,
  parameter int TRAILING_BITS = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ID_BITS       = $clog2(NUM_REQ)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  input  logic [NUM_REQ*UNPACKED_BITS-1:0]   i_req_data,
  input  logic [NUM_REQ*TRAILING_BITS-1:0]   i_req_trailing,
  input  logic [NUM_REQ-1:0]                 i_req_sticky,
  input  logic [NUM_REQ-1:0]                 i_req_stochastic,
  output logic [UNPACKED_BITS-1:0]           o_rnd_data,
  output logic [TRAILING_BITS-1:0]           o_rnd_trailing,
  output logic                               o_rnd_sticky,
  output logic                               o_rnd_stochastic,
  input  logic [UNPACKED_BITS-1:0]           i_rnd_result,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [UNPACKED_BITS-1:0]           o_out_data,
  output logic [ID_BITS-1:0]                 o_out_id,
  output logic                               o_busy
);

  localparam int ENTRY_W = UNPACKED_BITS + ID_BITS;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [ID_BITS-1:0]    r_rr_ptr;
  logic                  r_inflight;
  logic [ID_BITS-1:0]    r_inflight_id;

  logic [RR_MAX_REQ-1:0] w_valid_ext;
  rr_pick_t              w_pick;
  logic [ID_BITS-1:0]    w_gidx;
  logic [ID_BITS-1:0]    w_sel;
  logic [ID_BITS-1:0]    w_ptr_next;
  logic                  w_credit;
  logic                  w_grant;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [ENTRY_W-1:0]    w_head;

  assign w_valid_ext = RR_MAX_REQ'(i_req_valid);
  assign w_pick      = rr_pick(w_valid_ext, RR_IDX_W'(r_rr_ptr), NUM_REQ);
  assign w_gidx      = ID_BITS'(w_pick.idx);

  // Credit uses the pre-pop count: a slot freed this cycle is reusable next cycle
  assign w_credit = (int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH;
  assign w_grant  = ~i_rst & w_pick.found & w_credit;

  always_comb begin
    o_req_ready = '0;
    if (w_grant) o_req_ready[w_gidx] = 1'b1;
  end

  assign w_sel            = w_grant ? w_gidx : r_rr_ptr;
  assign o_rnd_data       = i_req_data[int'(w_sel)*UNPACKED_BITS +: UNPACKED_BITS];
  assign o_rnd_trailing   = i_req_trailing[int'(w_sel)*TRAILING_BITS +: TRAILING_BITS];
  assign o_rnd_sticky     = i_req_sticky[w_sel];
  assign o_rnd_stochastic = i_req_stochastic[w_sel];

  assign w_ptr_next = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + ID_BITS'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr      <= '0;
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant) begin
        r_rr_ptr      <= w_ptr_next;
        r_inflight_id <= w_gidx;
      end
    end
  end

  assign w_pop = o_out_valid & i_out_ready;

  round_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_data  ({i_rnd_result, r_inflight_id}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (o_out_valid),
    .o_count (w_fifo_count)
  );

  assign o_out_data = w_head[ENTRY_W-1:ID_BITS];
  assign o_out_id   = w_head[ID_BITS-1:0];
  assign o_busy     = r_inflight | (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_posit_round_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_posit_round_arbiter: directed stimulus with a scoreboard monitor  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_posit_round_arbiter;
  import posit_round_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic [31:0] req_trailing;
  logic [3:0]  req_sticky;
  logic [3:0]  req_stoch;
  logic [15:0] rnd_data;
  logic [7:0]  rnd_trailing;
  logic        rnd_sticky;
  logic        rnd_stoch;
  logic [15:0] rnd_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  res_entry_t q[$];
  logic [15:0] dtab [4];

  posit_round_arbiter #(
    .NUM_REQ(4), .UNPACKED_BITS(16), .TRAILING_BITS(8), .FIFO_DEPTH(4), .ID_BITS(2)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_data       (req_data),
    .i_req_trailing   (req_trailing),
    .i_req_sticky     (req_sticky),
    .i_req_stochastic (req_stoch),
    .o_rnd_data       (rnd_data),
    .o_rnd_trailing   (rnd_trailing),
    .o_rnd_sticky     (rnd_sticky),
    .o_rnd_stochastic (rnd_stoch),
    .i_rnd_result     (rnd_result),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_data       (out_data),
    .o_out_id         (out_id),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub round unit: one-cycle register of data XOR 16'h00FF
  always @(posedge clk) rnd_result <= rnd_data ^ 16'h00FF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input logic [15:0] d, input int id);
    res_entry_t e;
    e.data = d;
    e.id   = 2'(id);
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", 32'(busy), 0);
  endtask

  // Monitor: compare every accepted output against the scoreboard head
  always @(negedge clk) begin
    res_entry_t e;
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got data=%h id=%0d expected no output", out_data, out_id);
      end else begin
        e = q.pop_front();
        if (out_data !== e.data || out_id !== e.id) begin
          n_fail++;
          $display("FAIL out_entry: got data=%h id=%0d expected data=%h id=%0d",
                   out_data, out_id, e.data, e.id);
        end
      end
    end
    if (!rst && dut.r_inflight && (dut.w_fifo_count == 3'd4) && !(out_valid && out_ready)) begin
      n_tests++;
      n_fail++;
      $display("FAIL fifo_overflow: got push while full expected none");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dtab[0] = 16'h1111; dtab[1] = 16'h2222; dtab[2] = 16'h3333; dtab[3] = 16'h4444;
    rst          = 1'b1;
    req_data     = {dtab[3], dtab[2], dtab[1], dtab[0]};
    req_trailing = 32'h13121110;
    req_sticky   = 4'b0000;
    req_stoch    = 4'b0000;
    out_ready    = 1'b1;
    req_valid    = 4'b1111;

    // Reset state, requests already asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_out_data", 32'(out_data), 0);

    // All requesters valid from reset: rotation 0,1,2,3,... at full rate
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) check("stream_valid", 32'(out_valid), 1);
      expect_out(dtab[k % 4] ^ 16'h00FF, k % 4);
    end
    tick();
    req_valid = 4'b0000;
    wait_idle();

    // Single request from requester 2
    tick();
    req_data[32 +: 16] = 16'h1234;
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 32'(req_ready), 32'(4'b0100));
    check("single_rnd_data", 32'(rnd_data), 32'h1234);
    check("single_rnd_trail", 32'(rnd_trailing), 32'h12);
    check("single_rnd_stoch", 32'(rnd_stoch), 0);
    expect_out(16'h12CB, 2);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("single_t1_valid", 32'(out_valid), 0);
    check("single_t1_busy", 32'(busy), 1);
    @(negedge clk);
    check("single_t2_valid", 32'(out_valid), 1);
    @(negedge clk);
    check("single_t3_busy", 32'(busy), 0);
    check("single_t3_valid", 32'(out_valid), 0);
    req_data[32 +: 16] = dtab[2];

    // Backpressure: requester 1 only, out_ready low -> four grants then stall
    tick();
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      check("bp_ready", 32'(req_ready), (k < 4) ? 32'(4'b0010) : 32'd0);
      if (k < 4) expect_out(16'h22DD, 1);
    end
    check("bp_full_valid", 32'(out_valid), 1);
    tick(); out_ready = 1'b1;
    @(negedge clk); check("bp_pop_noready", 32'(req_ready), 0);
    tick(); out_ready = 1'b0;
    @(negedge clk); check("bp_one_more", 32'(req_ready), 32'(4'b0010));
    expect_out(16'h22DD, 1);
    // count 3 + inflight 1: push and pop together, no grant
    tick(); out_ready = 1'b1;
    @(negedge clk); check("pp_no_grant", 32'(req_ready), 0);
    tick(); out_ready = 1'b0;
    @(negedge clk); check("pp_count_held", 32'(req_ready), 32'(4'b0010));
    expect_out(16'h22DD, 1);
    tick();
    @(negedge clk); check("pp_full_again", 32'(req_ready), 0);

    // Drain one, then mode steering from requester 3
    tick(); req_valid = 4'b0000; out_ready = 1'b1;
    @(negedge clk); check("ms_pre_ready", 32'(req_ready), 0);
    tick();
    req_stoch[3] = 1'b1; req_sticky[3] = 1'b1; req_trailing[31:24] = 8'hA5;
    req_valid = 4'b1000;
    @(negedge clk);
    check("ms_ready", 32'(req_ready), 32'(4'b1000));
    check("ms_rnd_stoch", 32'(rnd_stoch), 1);
    check("ms_rnd_trail", 32'(rnd_trailing), 32'hA5);
    check("ms_rnd_sticky", 32'(rnd_sticky), 1);
    check("ms_rnd_data", 32'(rnd_data), 32'h4444);
    expect_out(16'h44BB, 3);
    tick(); out_ready = 1'b0; req_valid = 4'b0010;
    @(negedge clk); check("pre_rst_grant", 32'(req_ready), 32'(4'b0010));
    expect_out(16'h22DD, 1);

    // 3 entries + 1 in flight: asynchronous reset mid-cycle
    tick(); req_valid = 4'b1000;
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_valid", 32'(out_valid), 1);
    #2 rst = 1'b1;
    q.delete();
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(req_ready), 0);
    check("arst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; req_valid = 4'b0000; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 0);
      check("post_rst_busy", 32'(busy), 0);
      tick();
    end
    req_valid = 4'b1001;
    @(negedge clk); check("post_rst_first", 32'(req_ready), 32'(4'b0001));
    expect_out(16'h11EE, 0);
    tick(); req_valid = 4'b1000;
    @(negedge clk); check("post_rst_second", 32'(req_ready), 32'(4'b1000));
    expect_out(16'h44BB, 3);
    tick(); req_valid = 4'b0000;
    wait_idle();
    @(negedge clk);
    check("sb_empty", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
